branch_resolve_unit: RTL

// - Pipelined branch-condition resolver plus branch history table (BHT) for the pipelined CPU.
// - Evaluates 8 branch types on two DATA_W operands and registers taken/mispredict one cycle later.
// - Trains a table of 2-bit saturating counters indexed by PC bits.
// - Supplies the fetch stage with a combinational prediction read.

---
 rtl/branch_resolve_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver with 2-bit BHT; result latency 1 cycle, no backpressure (accepts every cycle).
// Optional macro BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  pred_idx_i,
  output logic              pred_taken_o,
  input  logic              valid_i,
  input  logic [2:0]        br_type_i,
  input  logic [DATA_W-1:0] src0_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [IDX_W-1:0]  res_idx_i,
  input  logic              pred_taken_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic              taken_o,
  output logic              mispredict_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       br_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  logic [1:0] bht_q [BHT_DEPTH];
  logic [1:0] ctr_cur;
  logic [1:0] ctr_d;
  logic       cond;
  logic       upd;
  logic       valid_q;
  logic       taken_q;
  logic       mispredict_q;

  always_comb begin
    cond = 1'b0;
    case (br_type_i)
      3'b000: cond = (src0_i == src1_i);
      3'b001: cond = ($signed(src0_i) <= $signed(src1_i));
      3'b010: cond = (src0_i != '0);
      3'b011: cond = (src0_i != src1_i);
      3'b100: cond = ($signed(src0_i) < $signed(src1_i));
      3'b101: cond = ($signed(src0_i) >= $signed(src1_i));
      3'b110: cond = (src0_i < src1_i);
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign upd     = valid_i & ~flush_i;
  assign ctr_cur = bht_q[res_idx_i];

  always_comb begin
    ctr_d = ctr_cur;
    if (cond) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
    end
  end

  // Fetch sees the stored value only; an update in the same cycle is visible next cycle.
  assign pred_taken_o = bht_q[pred_idx_i][1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      if (upd) bht_q[res_idx_i] <= ctr_d;
      valid_q      <= upd;
      taken_q      <= cond;
      mispredict_q <= cond ^ pred_taken_i;
    end
  end

  assign valid_o      = valid_q;
  assign taken_o      = taken_q;
  assign mispredict_o = mispredict_q;

`ifdef BRU_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (valid_q) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_q && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
